// File: rtl/multiplexador.sv
// Two-input mux with registered copies of the result and select, plus a saturating count of select changes.
// Latency: out is combinational; out_q, sel_q and sel_changes update one clk edge later.
// Backpressure: none, because the block accepts new inputs on every cycle.
module multiplexador #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] sel_changes
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // The ternary merges in0 and in1 bitwise when sel is unknown, so equal inputs still resolve.
    assign out = sel ? in1 : in0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            sel_q       <= 1'b0;
            sel_changes <= '0;
        end else begin
            out_q <= out;
            sel_q <= sel;
            if ((sel != sel_q) && (sel_changes != CNT_MAX)) begin
                sel_changes <= sel_changes + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_multiplexador.sv
// Scoreboard bench for multiplexador: one instance for each of the default, narrow-counter and wide-data configurations.
module tb_multiplexador;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst = 1'b1;

    logic       sel0 = 1'b0, in00 = 1'b0, in10 = 1'b0;
    logic       out0, outq0, selq0;
    logic [7:0] cnt0;

    logic       sel1 = 1'b0, in01 = 1'b0, in11 = 1'b0;
    logic       out1, outq1, selq1;
    logic [1:0] cnt1;

    logic       sel2 = 1'b0;
    logic [7:0] in02 = 8'h00, in12 = 8'h00;
    logic [7:0] out2, outq2;
    logic       selq2;
    logic [7:0] cnt2;

    multiplexador #(.WIDTH(1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .sel(sel0), .in0(in00), .in1(in10),
        .out(out0), .out_q(outq0), .sel_q(selq0), .sel_changes(cnt0)
    );
    multiplexador #(.WIDTH(1), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .sel(sel1), .in0(in01), .in1(in11),
        .out(out1), .out_q(outq1), .sel_q(selq1), .sel_changes(cnt1)
    );
    multiplexador #(.WIDTH(8), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .sel(sel2), .in0(in02), .in1(in12),
        .out(out2), .out_q(outq2), .sel_q(selq2), .sel_changes(cnt2)
    );

    // Gated clock, so the combinational checks can run with no edges at all.
    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic pop(input logic [31:0] got);
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: got %h expected <none>", got);
        end else begin
            e = sbq.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] tt;
        logic [2:0] v;
        logic       s;
        int         exp_cnt;

        #1;
        push("rst_outq", 0); push("rst_selq", 0); push("rst_cnt", 0);
        pop(outq0); pop(selq0); pop(cnt0);

        // Truth table indexed by {in0,in1,sel}, with no clock running and reset held.
        tt = 8'b1101_1000;
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            {in00, in10, sel0} = v;
            push("truth", {31'b0, tt[i]});
            #5;
            pop(out0);
        end

        // An unknown select with equal data still resolves.
        in00 = 1'b1; in10 = 1'b1; sel0 = 1'bx;
        push("xsel_eq", 1);
        #5;
        pop(out0);
        sel0 = 1'b0;
        push("rst_hold_outq", 0);
        #1;
        pop(outq0);

        // Registered path.
        rst = 1'b0;
        clk_en = 1'b1;
        in00 = 1'b1; in10 = 1'b0; sel0 = 1'b0;
        push("reg_outq1", 1); push("reg_cnt0", 0);
        tick();
        pop(outq0); pop(cnt0);
        sel0 = 1'b1;
        push("comb_out0", 0); push("outq_hold", 1);
        #1;
        pop(out0); pop(outq0);
        push("reg_outq0", 0); push("reg_selq1", 1); push("reg_cnt1", 1);
        tick();
        pop(outq0); pop(selq0); pop(cnt0);

        // Count five toggles, then hold the select for three edges.
        pulse_rst();
        s = 1'b0;
        exp_cnt = 0;
        for (int k = 1; k <= 5; k++) begin
            s = ~s;
            sel0 = s;
            exp_cnt++;
            push("cnt_toggle", exp_cnt);
            tick();
            pop(cnt0);
        end
        for (int k = 0; k < 3; k++) begin
            push("cnt_hold", 5);
            tick();
            pop(cnt0);
        end
        push("selq_hold", 1);
        pop(selq0);

        // Asynchronous reset in the middle of a run.
        in00 = 1'b1; in10 = 1'b1;
        sel0 = 1'b0;
        pulse_rst();
        s = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s = ~s;
            sel0 = s;
            tick();
        end
        push("mid_cnt4", 4); push("mid_outq1", 1);
        pop(cnt0); pop(outq0);
        #1;
        rst = 1'b1;
        push("arst_outq", 0); push("arst_selq", 0); push("arst_cnt", 0); push("arst_out", 1);
        #1;
        pop(outq0); pop(selq0); pop(cnt0); pop(out0);
        rst = 1'b0;
        push("rel_cnt0", 0);
        tick();
        pop(cnt0);
        sel0 = 1'b1;
        push("rel_cnt1", 1);
        tick();
        pop(cnt0);

        // Saturation on the 2-bit counter, including toggles while at max.
        pulse_rst();
        s = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            s = ~s;
            sel1 = s;
            push("sat_toggle", (k > 3) ? 3 : k);
            tick();
            pop(cnt1);
        end
        for (int k = 0; k < 2; k++) begin
            push("sat_hold", 3);
            tick();
            pop(cnt1);
        end

        // Wide data path.
        in02 = 8'hA5; in12 = 8'h3C; sel2 = 1'b0;
        push("wide_sel0", 8'hA5);
        #1;
        pop(out2);
        sel2 = 1'b1;
        push("wide_sel1", 8'h3C);
        #1;
        pop(out2);
        push("wide_outq", 8'h3C); push("wide_cnt", 1);
        tick();
        pop(outq2); pop(cnt2);

        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_leftover: got %0d expected 0", sbq.size());
        end

        clk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multiplexador.md
MULTIPLEXADOR -- requirements
Module: multiplexador

Interface
REQ-001 Parameter WIDTH, default 1: data width of in0, in1, out and out_q.
REQ-002 Parameter CNT_W, default 8: width of sel_changes.
REQ-003 Clocking and reset SHALL be one clock, with an asynchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all registers update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sel  input  1  select: 0 chooses in0, 1 chooses in1.
REQ-007 in0  input  WIDTH  data input 0.
REQ-008 in1  input  WIDTH  data input 1.
REQ-009 out  output  WIDTH  combinational mux result.
REQ-010 out_q  output  WIDTH  out registered on clk.
REQ-011 sel_q  output  1  sel registered on clk.
REQ-012 sel_changes  output  CNT_W  saturating count of clock edges where sel differs from sel_q.

Function
REQ-013 out SHALL equal in0 when sel=0 and in1 when sel=1, bit-for-bit across WIDTH.
- Purely combinational, zero-cycle latency.
- Independent of clk and rst; valid during reset.
REQ-014 out SHALL follow any input change within the same delta/settling time, with no clock required.
- The bench applies stimulus with no clock toggling and checks out.
REQ-015 If sel is X or Z, out SHALL be in0 when in0==in1; otherwise X (simulation only).
REQ-016 out_q SHALL load out on every rising clk edge when rst=0: one-cycle latency.
REQ-017 sel_q SHALL load sel on every rising clk edge when rst=0.
REQ-018 sel_changes SHALL increment by 1 on a rising edge when rst=0 and sel != sel_q.
- Saturates at 2^CNT_W-1; no wrap-around.
REQ-019 Simultaneous sel toggle and counter at max SHALL hold the count at max.
REQ-020 Both data inputs changing on the same edge as sel SHALL be treated like any other input change: out_q captures the mux of the new values.

Reset
REQ-021 Asserting rst SHALL immediately, with no clock needed, force out_q=0, sel_q=0 and sel_changes=0.
REQ-022 While rst=1, the registers SHALL hold their reset values.
- out SHALL continue to reflect the combinational mux.
REQ-023 Deassertion of rst SHALL take effect at the first rising clk edge after release.
- That edge compares sel against sel_q=0.
REQ-024 Reset mid-operation SHALL discard the accumulated count and registered data without glitching out.

Verification
REQ-025 Exhaustive truth table, WIDTH=1, no clock, 5 ns steps:
- (in0,in1,sel) = 000 -> out 0; 001 -> 0; 010 -> 0; 011 -> 1.
- 100 -> 1; 101 -> 0; 110 -> 1; 111 -> 1.
REQ-026 Registered path: in0=1, in1=0, sel=0, clock one edge -> out_q=1; set sel=1 -> out=0 immediately, out_q=0 after the next edge.
REQ-027 Counter: toggle sel on 5 consecutive edges from reset -> sel_changes=5; hold sel constant 3 edges -> sel_changes stays 5.
REQ-028 Saturation: CNT_W=2, toggle sel for 6 edges -> sel_changes=3 and remains 3.
REQ-029 Async reset mid-run: sel_changes=4, out_q=1; raise rst between edges -> all registers 0 before the next edge, out still equals the mux result.
REQ-030 Wide data: WIDTH=8, in0=8'hA5, in1=8'h3C -> sel=0 gives out=8'hA5, sel=1 gives out=8'h3C.
